// File: rtl/move_scan.sv
// Sequential checkers move-legality scanner: one diagonal direction per cycle, then DONE.
// Define MOVE_SCAN_FORCED_JUMP_EN to make `movable` enforce mandatory capture.
module move_scan (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] red,
    input  logic [31:0] black,
    input  logic [31:0] kings,
    input  logic        turn,
    output logic        busy,
    output logic        done,
    output logic [31:0] step_mask,
    output logic [31:0] jump_mask,
    output logic [31:0] movable,
    output logic        must_jump
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e      state_q, state_d;
    logic [1:0]  dir_q, dir_d;
    logic [31:0] own_q, own_d;
    logic [31:0] opp_q, opp_d;
    logic [31:0] occ_q, occ_d;
    logic [31:0] kings_q, kings_d;
    logic        turn_q, turn_d;
    logic [31:0] step_acc_q, step_acc_d;
    logic [31:0] jump_acc_q, jump_acc_d;
    logic [31:0] step_mask_q, step_mask_d;
    logic [31:0] jump_mask_q, jump_mask_d;

    logic [31:0] allow, s_occ, s_opp, s_occ2, step_term, jump_term;

    // Diagonal shift; off-board neighbours read as 1 so edges look occupied.
    function automatic logic [31:0] shift_dir(input logic [31:0] x, input logic [1:0] dir);
        logic [31:0] res;
        int          r, c, nr, nc;
        logic [4:0]  idx;
        res = '1;
        for (int i = 0; i < 32; i++) begin
            r  = i / 4;
            c  = i % 4;
            nr = dir[1] ? r + 1 : r - 1;
            if (dir[0]) begin
                nc = (r % 2 == 0) ? c : c + 1;
            end else begin
                nc = (r % 2 == 0) ? c - 1 : c;
            end
            if (nr >= 0 && nr <= 7 && nc >= 0 && nc <= 3) begin
                idx    = 5'(nr * 4 + nc);
                res[i] = x[idx];
            end
        end
        return res;
    endfunction

    always_comb begin
        if (!dir_q[1]) begin
            allow = turn_q ? kings_q : '1;
        end else begin
            allow = turn_q ? '1 : kings_q;
        end
        s_occ     = shift_dir(occ_q, dir_q);
        s_opp     = shift_dir(opp_q, dir_q);
        s_occ2    = shift_dir(s_occ, dir_q);
        step_term = own_q & allow & ~s_occ;
        jump_term = own_q & allow & s_opp & ~s_occ2;
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        own_d       = own_q;
        opp_d       = opp_q;
        occ_d       = occ_q;
        kings_d     = kings_q;
        turn_d      = turn_q;
        step_acc_d  = step_acc_q;
        jump_acc_d  = jump_acc_q;
        step_mask_d = step_mask_q;
        jump_mask_d = jump_mask_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    own_d      = turn ? black : red;
                    opp_d      = turn ? red : black;
                    occ_d      = red | black;
                    kings_d    = kings;
                    turn_d     = turn;
                    step_acc_d = '0;
                    jump_acc_d = '0;
                    dir_d      = 2'd0;
                    state_d    = StScan;
                end
            end
            StScan: begin
                step_acc_d = step_acc_q | step_term;
                jump_acc_d = jump_acc_q | jump_term;
                dir_d      = dir_q + 2'd1;
                if (dir_q == 2'd3) begin
                    step_mask_d = step_acc_d;
                    jump_mask_d = jump_acc_d;
                    state_d     = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            dir_q       <= 2'd0;
            own_q       <= '0;
            opp_q       <= '0;
            occ_q       <= '0;
            kings_q     <= '0;
            turn_q      <= 1'b0;
            step_acc_q  <= '0;
            jump_acc_q  <= '0;
            step_mask_q <= '0;
            jump_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            own_q       <= own_d;
            opp_q       <= opp_d;
            occ_q       <= occ_d;
            kings_q     <= kings_d;
            turn_q      <= turn_d;
            step_acc_q  <= step_acc_d;
            jump_acc_q  <= jump_acc_d;
            step_mask_q <= step_mask_d;
            jump_mask_q <= jump_mask_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign step_mask = step_mask_q;
    assign jump_mask = jump_mask_q;
    assign must_jump = |jump_mask_q;
`ifdef MOVE_SCAN_FORCED_JUMP_EN
    assign movable   = must_jump ? jump_mask_q : step_mask_q;
`else
    assign movable   = step_mask_q | jump_mask_q;
`endif

endmodule

// File: tb/tb_move_scan.sv
// Directed self-checking bench for move_scan with hand-computed expected masks.
module tb_move_scan;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] red, black, kings;
    logic        turn;
    logic        busy, done, must_jump;
    logic [31:0] step_mask, jump_mask, movable;

    int n_checks = 0;
    int n_errors = 0;

    move_scan dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .red       (red),
        .black     (black),
        .kings     (kings),
        .turn      (turn),
        .busy      (busy),
        .done      (done),
        .step_mask (step_mask),
        .jump_mask (jump_mask),
        .movable   (movable),
        .must_jump (must_jump)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_movable(input logic [31:0] s, input logic [31:0] j);
`ifdef MOVE_SCAN_FORCED_JUMP_EN
        return (j != 0) ? j : s;
`else
        return s | j;
`endif
    endfunction

    task automatic check_outputs(input string tag, input logic [31:0] s, input logic [31:0] j);
        check_eq({tag, ".step"}, step_mask, s);
        check_eq({tag, ".jump"}, jump_mask, j);
        check_eq({tag, ".movable"}, movable, exp_movable(s, j));
        check_eq({tag, ".must_jump"}, 32'(must_jump), 32'(j != 0));
    endtask

    task automatic set_board(input logic [31:0] r, input logic [31:0] b, input logic [31:0] k,
                             input logic t);
        red   = r;
        black = b;
        kings = k;
        turn  = t;
    endtask

    // Start at edge N, check busy/done over cycles N+1..N+6 and results at N+5.
    task automatic run_scan(input string tag, input logic [31:0] r, input logic [31:0] b,
                            input logic [31:0] k, input logic t,
                            input logic [31:0] s, input logic [31:0] j);
        @(negedge clock);
        set_board(r, b, k, t);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            check_eq($sformatf("%s.busy%0d", tag, c), 32'(busy), 32'd1);
            check_eq($sformatf("%s.done%0d", tag, c), 32'(done), 32'(c == 5));
        end
        check_outputs(tag, s, j);
        @(negedge clock);
        check_eq({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".idle_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        set_board('0, '0, '0, 1'b0);
        #12;
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.done", 32'(done), 32'd0);
        check_outputs("rst", 32'h0, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        run_scan("init", 32'hFFF00000, 32'h00000FFF, 32'h0, 1'b0, 32'h00F00000, 32'h0);
        run_scan("jump", 32'h80400000, 32'h00040000, 32'h0, 1'b0, 32'h80400000, 32'h00400000);
        run_scan("ledge", 32'h00010000, 32'h00001000, 32'h0, 1'b0, 32'h0, 32'h00010000);
        run_scan("king", 32'h00000010, 32'h00000001, 32'h00000001, 1'b1, 32'h0, 32'h00000001);
        run_scan("kblk", 32'h00000210, 32'h00000001, 32'h00000001, 1'b1, 32'h0, 32'h0);
        run_scan("empty", 32'h0, 32'h00000FFF, 32'h0, 1'b0, 32'h0, 32'h0);

        // Outputs hold while idle even if inputs move.
        run_scan("hold0", 32'h80400000, 32'h00040000, 32'h0, 1'b0, 32'h80400000, 32'h00400000);
        set_board(32'h0, 32'hFFFFFFFF, 32'h0, 1'b1);
        repeat (3) @(negedge clock);
        check_outputs("hold", 32'h80400000, 32'h00400000);

        // Second start in cycle N+2 with a different board must be ignored.
        @(negedge clock);
        set_board(32'hFFF00000, 32'h00000FFF, 32'h0, 1'b0);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        check_eq("hs.busy1", 32'(busy), 32'd1);
        @(posedge clock);
        #1 set_board(32'h80400000, 32'h00040000, 32'h0, 1'b0);
        start = 1'b1;
        @(negedge clock);
        check_eq("hs.busy2", 32'(busy), 32'd1);
        @(posedge clock);
        #1 start = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            @(negedge clock);
            check_eq($sformatf("hs.busy%0d", c), 32'(busy), 32'd1);
            check_eq($sformatf("hs.done%0d", c), 32'(done), 32'(c == 5));
        end
        check_outputs("hs", 32'h00F00000, 32'h0);
        @(negedge clock);
        check_eq("hs.idle", 32'(busy), 32'd0);

        // Reset during cycle N+3 of a scan after nonzero results are held.
        run_scan("pre", 32'h80400000, 32'h00040000, 32'h0, 1'b0, 32'h80400000, 32'h00400000);
        @(negedge clock);
        set_board(32'hFFF00000, 32'h00000FFF, 32'h0, 1'b0);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check_eq("mrst.busy", 32'(busy), 32'd0);
        check_eq("mrst.done", 32'(done), 32'd0);
        check_outputs("mrst", 32'h0, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            check_eq($sformatf("mrst.nodone%0d", c), 32'(done | busy), 32'd0);
        end
        run_scan("fresh", 32'hFFF00000, 32'h00000FFF, 32'h0, 1'b0, 32'h00F00000, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
